// File: rtl/aegnn_pkg.sv
// Shared types for the aegnn MM2S stream sink: FSM states, error bit indices, beat type.
package aegnn_pkg;

  localparam int unsigned AXIS_DATA_W = 128;

  typedef logic [AXIS_DATA_W-1:0] axis_beat_t;

  localparam int unsigned MM2S_ERR_EARLY = 0;
  localparam int unsigned MM2S_ERR_LATE  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRecv,
    StDone,
    StDrain
  } mm2s_state_e;

endpackage

// File: rtl/axis_mm2s_bank.sv
// One bank of burst storage: whole-bank clear, strobe-masked beat write, flat read port.
module axis_mm2s_bank #(
  parameter int unsigned DataW = 128,
  parameter int unsigned Depth = 8,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   we_i,
  input  logic [IdxW-1:0]        idx_i,
  input  logic [DataW-1:0]       data_i,
  input  logic [DataW/8-1:0]     strb_i,
  output logic [Depth*DataW-1:0] rd_data_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] wdata;

  // Strobed-off bytes are stored as zero rather than left untouched.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < DataW / 8; i++) begin
      wdata[i*8 +: 8] = strb_i[i] ? data_i[i*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      for (int k = 0; k < Depth; k++) begin
        mem_q[k] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdata;
    end
  end

  for (genvar k = 0; k < Depth; k++) begin : g_rd
    assign rd_data_o[k*DataW +: DataW] = mem_q[k];
  end

endmodule

// File: rtl/axis_mm2s_bank_sink.sv
// AXI-Stream MM2S sink into NUM_BUF ping-pong banks with TLAST framing checks.
// Optional statistics counters enabled by defining AXIS_MM2S_STATS_EN.
module axis_mm2s_bank_sink
  import aegnn_pkg::*;
#(
  parameter int unsigned MAX_BURST_LEN        = 8,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 128,
  parameter int unsigned NUM_BUF              = 2,
  localparam int unsigned LenW  = $clog2(MAX_BURST_LEN + 1),
  localparam int unsigned IdxW  = $clog2(MAX_BURST_LEN),
  localparam int unsigned BankW = $clog2(NUM_BUF),
  localparam int unsigned W     = C_S_AXIS_TDATA_WIDTH
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESETN,
  input  logic                                uip2axi_rd_en,
  input  logic [LenW-1:0]                     uip2axi_burst_len,
  input  logic                                uip2axi_buf_rel,
  input  logic [BankW-1:0]                    uip2axi_buf_rel_idx,
  output logic                                axi2uip_rd_done,
  output logic [BankW-1:0]                    axi2uip_rd_bank,
  output logic [LenW-1:0]                     axi2uip_rd_beats,
  output logic [1:0]                          axi2uip_rd_err,
  output logic                                axi2uip_idle,
`ifdef AXIS_MM2S_STATS_EN
  output logic [31:0]                         stat_beats,
  output logic [31:0]                         stat_stall,
`endif
  output logic [NUM_BUF*MAX_BURST_LEN*W-1:0]  rd_buffer,
  output logic                                S_AXIS_TREADY,
  input  logic [W-1:0]                        S_AXIS_TDATA,
  input  logic [W/8-1:0]                      S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID
);

  mm2s_state_e        state_q, state_d;
  logic [LenW-1:0]    len_q, len_d, beats_q, beats_d;
  logic [IdxW-1:0]    cnt_q, cnt_d;
  logic [BankW-1:0]   bank_q, bank_d, wptr_q, wptr_d;
  logic [1:0]         err_q, err_d;
  logic [NUM_BUF-1:0] busy_q, busy_d, bank_clr, bank_we;
  logic               beat_fire, cnt_last;

  assign S_AXIS_TREADY = (state_q == StRecv) || (state_q == StDrain);
  assign beat_fire     = S_AXIS_TVALID && S_AXIS_TREADY;
  assign cnt_last      = (LenW'(cnt_q) == len_q - LenW'(1));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    wptr_d   = wptr_q;
    err_d    = err_q;
    beats_d  = beats_q;
    busy_d   = busy_q;
    bank_clr = '0;
    bank_we  = '0;

    // Release is applied first so a DONE on the same bank overrides it.
    if (uip2axi_buf_rel && (32'(uip2axi_buf_rel_idx) < NUM_BUF)) begin
      busy_d[uip2axi_buf_rel_idx] = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (uip2axi_rd_en) begin
          len_d   = (uip2axi_burst_len == '0) ? LenW'(MAX_BURST_LEN) : uip2axi_burst_len;
          bank_d  = wptr_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!busy_q[bank_q]) begin
          bank_clr[bank_q] = 1'b1;
          cnt_d            = '0;
          state_d          = StRecv;
        end
      end
      StRecv: begin
        if (beat_fire) begin
          bank_we[bank_q] = 1'b1;
          if (S_AXIS_TLAST || cnt_last) begin
            state_d = StDone;
            err_d   = '0;
            beats_d = len_q;
            if (!cnt_last) begin
              err_d[MM2S_ERR_EARLY] = 1'b1;
              beats_d               = LenW'(cnt_q) + LenW'(1);
            end else if (!S_AXIS_TLAST) begin
              err_d[MM2S_ERR_LATE] = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        busy_d[bank_q] = 1'b1;
        wptr_d  = (wptr_q == BankW'(NUM_BUF - 1)) ? '0 : wptr_q + BankW'(1);
        state_d = err_q[MM2S_ERR_LATE] ? StDrain : StIdle;
      end
      StDrain: begin
        if (beat_fire && S_AXIS_TLAST) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      bank_q  <= '0;
      wptr_q  <= '0;
      err_q   <= '0;
      beats_q <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      wptr_q  <= wptr_d;
      err_q   <= err_d;
      beats_q <= beats_d;
      busy_q  <= busy_d;
    end
  end

  assign axi2uip_rd_done  = (state_q == StDone);
  assign axi2uip_idle     = (state_q == StIdle);
  assign axi2uip_rd_bank  = bank_q;
  assign axi2uip_rd_beats = beats_q;
  assign axi2uip_rd_err   = err_q;

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_bank
    axis_mm2s_bank #(
      .DataW (W),
      .Depth (MAX_BURST_LEN)
    ) u_bank (
      .clk_i     (S_AXIS_ACLK),
      .rst_ni    (S_AXIS_ARESETN),
      .clr_i     (bank_clr[b]),
      .we_i      (bank_we[b]),
      .idx_i     (cnt_q),
      .data_i    (S_AXIS_TDATA),
      .strb_i    (S_AXIS_TSTRB),
      .rd_data_o (rd_buffer[b*MAX_BURST_LEN*W +: MAX_BURST_LEN*W])
    );
  end

`ifdef AXIS_MM2S_STATS_EN
  logic [31:0] stat_beats_q, stat_beats_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_beats_d = stat_beats_q;
    stat_stall_d = stat_stall_q;
    if (beat_fire && (stat_beats_q != '1)) stat_beats_d = stat_beats_q + 32'd1;
    if ((state_q == StRecv) && !S_AXIS_TVALID && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      stat_beats_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_stall = stat_stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/axis_mm2s_bank_sink.md
Name: axis_mm2s_bank_sink

Overview:
Parametrised successor to the single-buffer AXI-Stream MM2S sink. It accepts runtime-length bursts (1..MAX_BURST_LEN beats) into NUM_BUF ping-pong banks. This lets the user IP consume one bank while the next one fills. It checks TLAST framing against the requested length and reports early or late TLAST, and it drains over-long packets. It sits between the PS DMA MM2S stream and the aegnn user IP.

Parameters:
MAX_BURST_LEN, 8, maximum beats per burst (power of 2, >=2).
C_S_AXIS_TDATA_WIDTH, 128, stream data width (32/64/128).
NUM_BUF, 2, number of banks (2..4).

Ports:
S_AXIS_ACLK  in  1  clock.
S_AXIS_ARESETN  in  1  synchronous active-low reset.
uip2axi_rd_en  in  1  pulse: arm one burst.
uip2axi_burst_len  in  $clog2(MAX_BURST_LEN+1)  beats requested, sampled with rd_en; 0 means MAX_BURST_LEN.
uip2axi_buf_rel  in  1  pulse: user releases a bank.
uip2axi_buf_rel_idx  in  $clog2(NUM_BUF)  bank being released.
axi2uip_rd_done  out  1  pulse: burst stored.
axi2uip_rd_bank  out  $clog2(NUM_BUF)  bank of the completed burst, valid with rd_done.
axi2uip_rd_beats  out  $clog2(MAX_BURST_LEN+1)  beats stored, valid with rd_done.
axi2uip_rd_err  out  2  [0] early TLAST, [1] late/missing TLAST; valid with rd_done.
axi2uip_idle  out  1  FSM in IDLE.
rd_buffer  out  NUM_BUF*MAX_BURST_LEN*C_S_AXIS_TDATA_WIDTH  bank b, beat k at [(b*MAX_BURST_LEN+k)*W +: W].
S_AXIS_TREADY  out  1.
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH.
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8.
S_AXIS_TLAST  in  1.
S_AXIS_TVALID  in  1.

Behaviour:
- Reset: all outputs 0 except axi2uip_idle=1. rd_buffer is 0, all banks free, write-bank pointer 0, FSM IDLE. Reset mid-burst aborts the burst; no done pulse.
- FSM states:
  - IDLE: rd_en latches the length and target bank = write pointer, then goes to WAIT.
  - WAIT: if the target bank is free, zero the whole bank and go to RECV the next cycle.
  - RECV: accept beats.
  - DONE: one cycle; rd_done=1.
  - DRAIN: discard beats.
  - DONE goes to DRAIN if a late error was flagged, otherwise to IDLE. DRAIN goes to IDLE on the TLAST handshake.
- rd_en outside IDLE is ignored.
- S_AXIS_TREADY=1 only in RECV and DRAIN. It is registered-free: a combinational decode of the state.
- Handshake: beat accepted when TVALID&&TREADY.
  - Store TDATA at beat index cnt. Bytes with TSTRB=0 are written as 0x00.
  - cnt increments per accepted beat.
  - TVALID low stalls with no side effects.
- Burst close, on the accepted beat where cnt==len-1 or TLAST=1:
  - TLAST with cnt<len-1: err[0]=1, beats=cnt+1.
  - cnt==len-1 without TLAST: err[1]=1, beats=len, then DRAIN.
  - Both together: no error.
- Latency: rd_done asserts in the cycle after the closing beat. rd_buffer data is stable from that cycle until the bank is released and re-armed.
- Bank bookkeeping:
  - DONE marks the bank busy and advances the write pointer mod NUM_BUF.
  - buf_rel clears busy for buf_rel_idx. A release of a free bank is ignored.
  - Release and DONE in the same cycle on different banks both take effect.
  - Release of the bank currently in DONE has DONE win, so the bank stays busy.
- All banks busy: the block waits in WAIT with TREADY=0 until a release, then proceeds the next cycle.
- Words beyond beats in a bank read 0, because the bank is cleared on entry to RECV.

Optional Feature:
AXIS_MM2S_STATS_EN.
- Defined: adds outputs stat_beats (32b, every accepted beat including drained ones) and stat_stall (32b, cycles with TREADY=1 and TVALID=0 in RECV). Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- aegnn package holds:
  - the mm2s_state_e enum (IDLE, WAIT, RECV, DONE, DRAIN);
  - MM2S_ERR_EARLY=0 and MM2S_ERR_LATE=1 bit indices;
  - the axis_beat_t typedef parameterised via localparam width.
- One sub-module, axis_mm2s_bank: a single bank's storage with clear, beat-write with TSTRB byte masking, and a flat read port. It is instantiated NUM_BUF times.

Test Plan:
- len=4, 4 beats 0x1..0x4, TLAST on beat 4, TVALID always 1 -> TREADY high for 4 cycles, rd_done 1 cycle later with bank=0, beats=4, err=0; bank0 words 0..3 = 1..4, words 4..7 = 0.
- len=8, TLAST on beat 3 -> done with beats=3, err=2'b01; TREADY drops after beat 3.
- len=2, packet of 5 beats with TLAST on beat 5 -> done after beat 2 with err=2'b10, beats 3..5 drained with TREADY=1; idle=1 after beat 5; stat_beats=5 if STATS_EN.
- Three bursts with no release (NUM_BUF=2) -> banks 0 and 1 complete, third stays in WAIT with TREADY=0; buf_rel idx=0 -> third burst fills bank 0.
- TSTRB=16'h00FF on beat 0 with TDATA all-ones -> word0 = 0x0000..00FF..FF (lower 8 bytes all-ones, upper 8 bytes zero).
- Assert ARESETN=0 mid-RECV after 2 beats -> no rd_done, all outputs 0, idle=1; the next rd_en lands in bank 0.
